// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern sequencer (rotate, bounce, fill/drain).
// Define LED_SEQUENCER_ACTIVE_LOW_EN to drive ~pattern on led for active-low LEDs.
module led_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNTMAX = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [WIDTH-1:0] led,
  output logic             step
);

  typedef enum logic [1:0] {
    ROT_L  = 2'b00,
    ROT_R  = 2'b01,
    BOUNCE = 2'b10,
    FILL   = 2'b11
  } mode_e;

  localparam logic [31:0]      TERM = 32'(CNTMAX - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [31:0]      presc_q, presc_d;
  logic [2:0]       tick_q, tick_d;
  logic [2:0]       lim;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [WIDTH-1:0] rst_led;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic             init_q;
  logic             step_q, step_d;
  mode_e            mode_q, mode_d;
  mode_e            mode_in;
  logic             base_tick;
  logic             adv;
  logic             onehot;

  assign mode_in = mode_e'(mode);

`ifdef LED_SEQUENCER_ACTIVE_LOW_EN
  assign led_d   = ~pat_d;
  assign rst_led = ~ONE;
`else
  assign led_d   = pat_d;
  assign rst_led = ONE;
`endif

  // Next-state: mode change load, prescaler/tick timing and pattern steps.
  always_comb begin
    presc_d   = presc_q;
    tick_d    = tick_q;
    pat_d     = pat_q;
    dir_d     = dir_q;
    fill_d    = fill_q;
    mode_d    = mode_q;
    step_d    = 1'b0;
    lim       = 3'((4'd1 << speed) - 4'd1);
    onehot    = (pat_q != '0) && ((pat_q & (pat_q - ONE)) == '0);
    base_tick = en && (presc_q == TERM);
    adv       = base_tick && (tick_q >= lim);
    if (mode_in != mode_q) begin
      mode_d  = mode_in;
      presc_d = '0;
      tick_d  = '0;
      dir_d   = 1'b1;
      fill_d  = 1'b1;
      pat_d   = (mode_in == FILL) ? '0 : ONE;
    end else begin
      if (en) begin
        presc_d = base_tick ? '0 : presc_q + 32'd1;
        if (base_tick) tick_d = adv ? 3'd0 : tick_q + 3'd1;
        if (adv) begin
          step_d = 1'b1;
          unique case (mode_q)
            ROT_L: pat_d = onehot ?
              {pat_q[WIDTH-2:0], pat_q[WIDTH-1]} : ONE;
            ROT_R: pat_d = onehot ?
              {pat_q[0], pat_q[WIDTH-1:1]} : ONE;
            BOUNCE: begin
              if (!onehot) begin
                pat_d = ONE;
                dir_d = 1'b1;
              end else if (dir_q) begin
                if (pat_q[WIDTH-1]) begin
                  pat_d = pat_q >> 1;
                  dir_d = 1'b0;
                end else begin
                  pat_d = pat_q << 1;
                end
              end else begin
                if (pat_q[0]) begin
                  pat_d = pat_q << 1;
                  dir_d = 1'b1;
                end else begin
                  pat_d = pat_q >> 1;
                end
              end
            end
            FILL: begin
              if (fill_q) begin
                pat_d  = {pat_q[WIDTH-2:0], 1'b1};
                fill_d = ~(&pat_d);
              end else begin
                pat_d  = {pat_q[WIDTH-2:0], 1'b0};
                fill_d = (pat_d == '0);
              end
            end
          endcase
        end
      end
      // First cycle out of reset: reset shows one-hot, fill mode starts empty.
      if (init_q) begin
        pat_d  = (mode_q == FILL) ? '0 : ONE;
        fill_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= '0;
      pat_q   <= ONE;
      led_q   <= rst_led;
      dir_q   <= 1'b1;
      fill_q  <= 1'b1;
      mode_q  <= mode_in;
      init_q  <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      pat_q   <= pat_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      mode_q  <= mode_d;
      init_q  <= 1'b0;
      step_q  <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: vector table, directed corner cases and random
// stimulus against a sequence-index reference model.
module tb_led_sequencer;

  localparam int W  = 4;
  localparam int CM = 4;
`ifdef LED_SEQUENCER_ACTIVE_LOW_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [1:0]   speed = 2'b00;
  logic [W-1:0] led;
  logic         step;

  int checks = 0;
  int failures = 0;

  led_sequencer #(.WIDTH(W), .CNTMAX(CM)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .speed(speed),
    .led  (led),
    .step (step)
  );

  always #5 clk = ~clk;

  // Reference model: position in the mode's step sequence plus timing counts.
  int m_mode = 0;
  int m_k = 0;
  int m_cnt = 0;
  int m_ticks = 0;
  bit m_rstd = 1'b1;
  bit m_step = 1'b0;

  function automatic logic [W-1:0] dl(logic [W-1:0] p);
    return AL ? ~p : p;
  endfunction

  function automatic logic [W-1:0] m_pat();
    int pos;
    if (m_rstd) return W'(1);
    case (m_mode)
      0, 1: return W'(1 << m_k);
      2: begin
        pos = (m_k < W) ? m_k : 2 * W - 2 - m_k;
        return W'(1 << pos);
      end
      default: begin
        if (m_k <= W) return W'((1 << m_k) - 1);
        return W'(((1 << W) - 1) & ~((1 << (m_k - W)) - 1));
      end
    endcase
  endfunction

  function automatic int m_next(int k);
    case (m_mode)
      0: return (k + 1) % W;
      1: return (k + W - 1) % W;
      2: return (k + 1) % (2 * W - 2);
      default: return (k + 1) % (2 * W);
    endcase
  endfunction

  task automatic m_update();
    m_step = 1'b0;
    if (rst) begin
      m_mode = int'(mode);
      m_k = 0; m_cnt = 0; m_ticks = 0;
      m_rstd = 1'b1;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_k = 0; m_cnt = 0; m_ticks = 0;
      m_rstd = 1'b0;
    end else begin
      m_rstd = 1'b0;
      if (en) begin
        m_cnt++;
        if (m_cnt == CM) begin
          m_cnt = 0;
          m_ticks++;
          if (m_ticks >= (1 << speed)) begin
            m_ticks = 0;
            m_step = 1'b1;
            m_k = m_next(m_k);
          end
        end
      end
    end
  endtask

  task automatic chk(string name, logic [W-1:0] lexp, logic sexp);
    checks++;
    if (led !== lexp || step !== sexp) begin
      failures++;
      $display("FAIL %s: led=%b step=%b expected led=%b step=%b",
               name, led, step, lexp, sexp);
    end
  endtask

  task automatic cyc(bit cmp);
    @(posedge clk);
    m_update();
    #1;
    if (cmp) chk("model", dl(m_pat()), m_step);
  endtask

  // Waits for the next step pulse; checks its spacing and new pattern.
  task automatic next_step(string name, logic [W-1:0] pexp, int gap);
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!step && n < 200);
    checks++;
    if (step !== 1'b1 || n != gap || led !== dl(pexp)) begin
      failures++;
      $display("FAIL %s: gap=%0d led=%b step=%b expected gap=%0d led=%b",
               name, n, led, step, gap, dl(pexp));
    end
  endtask

  typedef struct {
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [1:0]   speed;
    logic [W-1:0] pat;
    logic         stp;
  } vec_t;

  vec_t tbl[17];
  logic [W-1:0] bseq[6];
  logic [W-1:0] fseq[8];
  logic [W-1:0] held;

  initial begin
    tbl = '{
      '{1'b1, 1'b1, 2'd0, 2'd0, 4'b0001, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0001, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0001, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0001, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0010, 1'b1},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0010, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0010, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0010, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0100, 1'b1},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0100, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0100, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0100, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b1000, 1'b1},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b1000, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b1000, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b1000, 1'b0},
      '{1'b0, 1'b1, 2'd0, 2'd0, 4'b0001, 1'b1}
    };
    bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    fseq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
             4'b1110, 4'b1100, 4'b1000, 4'b0000};

    // Rotate-left from reset, one vector per cycle.
    for (int i = 0; i < 17; i++) begin
      rst   = tbl[i].rst;
      en    = tbl[i].en;
      mode  = tbl[i].mode;
      speed = tbl[i].speed;
      cyc(1);
      chk($sformatf("vec%0d", i), dl(tbl[i].pat), tbl[i].stp);
    end

    // Mode 00 -> 01 while showing 0100.
    next_step("rotl_0010", 4'b0010, 4);
    next_step("rotl_0100", 4'b0100, 4);
    mode = 2'b01;
    cyc(1);
    chk("mode_chg_load", dl(4'b0001), 1'b0);
    next_step("rotr_first", 4'b1000, 4);
    next_step("rotr_second", 4'b0100, 4);

    // Reset mid-sequence at 1000 in mode 00.
    mode = 2'b00;
    cyc(1);
    chk("mode_back_load", dl(4'b0001), 1'b0);
    next_step("pre_rst_0010", 4'b0010, 4);
    next_step("pre_rst_0100", 4'b0100, 4);
    next_step("pre_rst_1000", 4'b1000, 4);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid", dl(4'b0001), 1'b0);
    rst = 1'b0;
    next_step("post_rst_first", 4'b0010, 4);

    // Bounce.
    mode = 2'b10;
    cyc(1);
    chk("bounce_load", dl(4'b0001), 1'b0);
    for (int i = 0; i < 6; i++)
      next_step($sformatf("bounce%0d", i), bseq[i], 4);

    // Fill/drain.
    mode = 2'b11;
    cyc(1);
    chk("fill_load", dl(4'b0000), 1'b0);
    for (int i = 0; i < 8; i++)
      next_step($sformatf("fill%0d", i), fseq[i], 4);

    // Reset in fill mode: one-hot during reset, empty the cycle after.
    rst = 1'b1;
    cyc(1);
    chk("fill_rst", dl(4'b0001), 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("fill_after_rst", dl(4'b0000), 1'b0);
    next_step("fill_rst_first", 4'b0001, 3);

    // Slowest speed with a 10-cycle freeze mid-interval.
    mode  = 2'b00;
    speed = 2'b11;
    cyc(1);
    chk("slow_load", dl(4'b0001), 1'b0);
    next_step("slow_first", 4'b0010, 32);
    for (int i = 0; i < 10; i++) cyc(1);
    held = led;
    en = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1);
    chk("freeze_hold", held, 1'b0);
    en = 1'b1;
    next_step("slow_after_freeze", 4'b0100, 22);

    // Speed drop after ticks accumulated: step on the next base tick.
    for (int i = 0; i < 12; i++) cyc(1);
    speed = 2'b00;
    next_step("speed_drop", 4'b1000, 4);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 39) == 0) speed = 2'($urandom);
      en = ($urandom_range(0, 9) != 0);
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
